instr_reg_ctrl: RTL and testbench
=================================

# instr_reg_ctrl

Write-arbitration and playback controller for the 32-entry `instr_register`. It shares the register's single write port between two requesters using a round-robin valid/grant handshake, and it tracks the write pointer and fill count. On command it sequences `read_pointer` through every stored entry so that a downstream consumer sees each `instruction_word` in write order. It sits directly in front of `instr_register` and drives all of that block's inputs except `clk` and `reset_n`.

## Interface
- `OP_W`, 32: operand width; matches `operand_t`.
- `OPC_W`, 4: opcode width; matches `opcode_t`.
- `ADDR_W`, 5: pointer width; matches `address_t`.
- `DEPTH`, 32: number of register entries; equals 2**ADDR_W.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  requester write-valid.
- `opc0`, `opc1`  in  OPC_W  requester opcode.
- `a0`, `a1`, `b0`, `b1`  in  OP_W  requester operands.
- `gnt0`, `gnt1`  out  1  combinational grant; a transfer happens on an edge where req&gnt are both high.
- `clear`  in  1  synchronous pulse that empties the bookkeeping.
- `start`  in  1  pulse that begins playback.
- `load_en`  out  1  to `instr_register`.
- `write_pointer`, `read_pointer`  out  ADDR_W  to `instr_register`.
- `opcode`  out  OPC_W  to `instr_register`.
- `operand_a`, `operand_b`  out  OP_W  to `instr_register`.
- `rd_valid`  out  1  high when `read_pointer` addresses a live entry during playback.
- `done`  out  1  one-cycle pulse at the end of playback.
- `count`  out  ADDR_W+1  number of entries written, 0..DEPTH.
- `full`  out  1  high when `count == DEPTH`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, PLAY, DONE.
  - IDLE→PLAY on `start` when `count>0`.
  - IDLE→DONE on `start` when `count==0`.
  - PLAY→DONE when `read_pointer==count-1`.
  - DONE→IDLE unconditionally.
- **Grant rule:** grants are possible only in IDLE, with `!full`, `!start` and `!clear`.
  - `gnt0 = req0 & (!req1 | last==1)`.
  - `gnt1 = req1 & (!req0 | last==0)`.
  - At most one grant is high per cycle.
  - `last` records the most recently granted requester and resets to 1, so requester 0 wins the first tie.
- **Requester obligation:** hold `req` and payload stable until a cycle with gnt high. After that cycle it may drop `req` or present the next item.
- **On a transfer edge:**
  - Register the payload onto `opcode`/`operand_a`/`operand_b`.
  - Set `write_pointer = count[ADDR_W-1:0]` and set `load_en=1` for exactly the next cycle.
  - Increment `count` and update `last`.
- **Write pointer:** there is no wrap-around. Once `count==DEPTH`, all grants stay low until `clear` or reset.
- **`clear` (IDLE only):** sets `count=0`.
  - Stored register contents are untouched.
  - `clear` has priority over `req` and `start` in the same cycle.
  - `clear` is ignored outside IDLE.
- **`start`:** ignored outside IDLE. Priority order in IDLE is `clear` > `start` > grant.
- **PLAY:**
  - `read_pointer` starts at 0 and increments once per cycle.
  - `rd_valid=1` throughout PLAY.
  - No grants are issued.
  - `instruction_word` is combinational on `read_pointer`, so the consumer samples it together with `rd_valid`.
- **DONE:** `done=1`, `rd_valid=0`, and `read_pointer` returns to 0.
- **Reset values:**
  - FSM=IDLE, `count=0`, `last=1`.
  - `load_en=0`, `write_pointer=0`, `read_pointer=0`.
  - `opcode=0`, `operands=0`.
  - `rd_valid=0`, `done=0`, `full=0`, `busy=0`.
  - Asserting reset mid-PLAY or mid-write aborts immediately to these values; no `done` pulse is produced.

## Timing
- Grant-to-write latency: handshake at edge N, `load_en` high in cycle N+1, `instr_register` writes at edge N+1.
- Two requesters alternating can produce back-to-back writes; peak throughput is 1 per cycle.
- A `start` in the cycle right after a final transfer is legal. `count` already includes that entry, and its write completes before the entry is first read.
- Playback duration: `count` cycles of `rd_valid`, then 1 cycle of `done`. `busy` stays high for `count+1` cycles.
- `start` with `count==0`: `done` is high in the next cycle and `rd_valid` never asserts.
- `full` and `count` are registered and update on the transfer edge.

## Test plan
- **Reset mid-PLAY:**
  - Stimulus: write 3 entries, `start`, then assert `reset_n=0` after 1 `rd_valid` cycle.
  - Required response: all outputs take reset values asynchronously, there is no `done`, and `count=0`.
- **Contention:**
  - Stimulus: `req0` and `req1` held continuously for 4 grants.
  - Required response: grant order is 0,1,0,1; `write_pointer` is 0,1,2,3; each `load_en` follows its grant by 1 cycle.
- **Playback:**
  - Stimulus: write ADD a=5 b=3, then SUB a=9 b=4, then `start`.
  - Required response: `read_pointer` 0,1 with `rd_valid`; `instruction_word` results are 8 and 5; `done` pulses in the third cycle.
- **Full:**
  - Stimulus: 32 writes, then `req0` held.
  - Required response: `full=1`, `count=32`, `gnt0` stays 0. After `clear`, `count=0` and the next grant uses `write_pointer=0`.
- **Priority and empty playback:**
  - Stimulus: `start` and `req0` in the same IDLE cycle with `count=0`.
  - Required response: no grant; `done` high the next cycle; no `rd_valid`.
- **Ignored commands:**
  - Stimulus: `clear` and `start` asserted during PLAY.
  - Required response: both are ignored; playback completes over the full `count`.

Source files
------------

// File: rtl/instr_reg_ctrl.sv
// rtl/instr_reg_ctrl.sv - write arbiter and playback sequencer for instr_register
module instr_reg_ctrl #(
  parameter int OP_W   = 32,
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [OPC_W-1:0]  opc0,
  input  logic [OPC_W-1:0]  opc1,
  input  logic [OP_W-1:0]   a0,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   b0,
  input  logic [OP_W-1:0]   b1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              clear,
  input  logic              start,
  output logic              load_en,
  output logic [ADDR_W-1:0] write_pointer,
  output logic [ADDR_W-1:0] read_pointer,
  output logic [OPC_W-1:0]  opcode,
  output logic [OP_W-1:0]   operand_a,
  output logic [OP_W-1:0]   operand_b,
  output logic              rd_valid,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy
);

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t           state;
  logic             last;       // most recently granted requester (1 => req0 wins next tie)
  logic             grant_ok;
  logic             xfer;
  logic [CNT_W-1:0] last_idx;

  // Grants only while idle with room and no higher-priority command; held low in reset
  assign grant_ok = reset_n && (state == IDLE) && !full && !start && !clear;
  assign gnt0     = grant_ok && req0 && (!req1 || last);
  assign gnt1     = grant_ok && req1 && (!req0 || !last);
  assign xfer     = gnt0 | gnt1;
  assign last_idx = count - CNT_W'(1);

  // Single FSM: arbitration bookkeeping in IDLE, pointer sweep in PLAY, pulse in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      count         <= '0;
      full          <= 1'b0;
      load_en       <= 1'b0;
      write_pointer <= '0;
      read_pointer  <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      load_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            // Bookkeeping only; the register array keeps its contents
            count <= '0;
            full  <= 1'b0;
          end else if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              state        <= PLAY;
              rd_valid     <= 1'b1;
              read_pointer <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (xfer) begin
            opcode        <= gnt0 ? opc0 : opc1;
            operand_a     <= gnt0 ? a0 : a1;
            operand_b     <= gnt0 ? b0 : b1;
            write_pointer <= count[ADDR_W-1:0];
            load_en       <= 1'b1;
            count         <= count + CNT_W'(1);
            full          <= (count == DEPTH_C - CNT_W'(1));
            last          <= gnt1;
          end
        end
        PLAY: begin
          if ({1'b0, read_pointer} == last_idx) begin
            state        <= DONE;
            rd_valid     <= 1'b0;
            done         <= 1'b1;
            read_pointer <= '0;
          end else begin
            read_pointer <= read_pointer + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// tb/tb_instr_reg_ctrl.sv - randomized self-checking bench for instr_reg_ctrl
module tb_instr_reg_ctrl;
  localparam int OP_W = 32, OPC_W = 4, ADDR_W = 5, DEPTH = 32;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'd1, OPC_SUB = 4'd2;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
  } item_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, clear = 1'b0, start = 1'b0;
  logic [OPC_W-1:0] opc0 = '0, opc1 = '0;
  logic [OP_W-1:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic gnt0, gnt1, load_en, rd_valid, done, full, busy;
  logic [ADDR_W-1:0] write_pointer, read_pointer;
  logic [OPC_W-1:0]  opcode;
  logic [OP_W-1:0]   operand_a, operand_b;
  logic [ADDR_W:0]   count;

  instr_reg_ctrl #(.OP_W(OP_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .opc0(opc0), .opc1(opc1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .clear(clear), .start(start),
    .load_en(load_en), .write_pointer(write_pointer), .read_pointer(read_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b), .rd_valid(rd_valid),
    .done(done), .count(count), .full(full), .busy(busy));

  always #5 clk = ~clk;

  // Stand-in for instr_register storage
  item_t tbmem [DEPTH];
  always @(posedge clk) if (load_en) tbmem[write_pointer] <= {opcode, operand_a, operand_b};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fill level, arbitration history, written-item list, playback position
  int    m_count, m_pos, m_wp;
  bit    m_last, m_play, m_done, m_load;
  item_t m_out;
  item_t wr_q[$];
  // Requester agents
  item_t it0, it1;
  bit    pend0, pend1, seen0, seen1;

  task automatic model_reset();
    m_count = 0; m_pos = 0; m_wp = 0; m_last = 1'b1; m_play = 0; m_done = 0; m_load = 0;
    m_out = '0; wr_q.delete();
  endtask

  function automatic item_t rand_item();
    item_t t;
    t.opc = OPC_W'($urandom);
    t.a = $urandom;
    t.b = $urandom;
    return t;
  endfunction

  function automatic logic [OP_W-1:0] alu(input item_t e);
    if (e.opc == OPC_ADD) return e.a + e.b;
    if (e.opc == OPC_SUB) return e.a - e.b;
    return '0;
  endfunction

  task automatic drive_reqs(input int p0, input int p1);
    if (!pend0 && $urandom_range(0, 99) < p0) begin pend0 = 1; it0 = rand_item(); end
    if (!pend1 && $urandom_range(0, 99) < p1) begin pend1 = 1; it1 = rand_item(); end
    req0 = pend0; {opc0, a0, b0} = it0;
    req1 = pend1; {opc1, a1, b1} = it1;
  endtask

  // One clock: compare every output against the model, then advance the model at the edge
  task automatic tick();
    bit idle, ok, g0, g1;
    #1;
    idle = !m_play && !m_done;
    ok = idle && (m_count < DEPTH) && !start && !clear;
    g0 = ok && req0 && (!req1 || m_last);
    g1 = ok && req1 && (!req0 || !m_last);
    seen0 = gnt0; seen1 = gnt1;
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("load_en", load_en, m_load);
    chk("write_pointer", write_pointer, m_wp);
    chk("payload", {opcode, operand_a, operand_b}, m_out);
    chk("rd_valid", rd_valid, m_play);
    chk("read_pointer", read_pointer, m_play ? m_pos : 0);
    chk("done", done, m_done);
    chk("busy", busy, m_play || m_done);
    chk("count", count, m_count);
    chk("full", full, m_count == DEPTH);
    if (m_play && m_pos < wr_q.size()) chk("play_entry", tbmem[read_pointer], wr_q[m_pos]);
    @(posedge clk);
    m_load = 0;
    if (m_done) m_done = 0;
    else if (m_play) begin
      if (m_pos == m_count - 1) begin m_play = 0; m_done = 1; m_pos = 0; end
      else m_pos++;
    end else if (clear) begin
      m_count = 0; wr_q.delete();
    end else if (start) begin
      if (m_count > 0) begin m_play = 1; m_pos = 0; end
      else m_done = 1;
    end else if (g0 || g1) begin
      m_out = g0 ? it0 : it1;
      wr_q.push_back(m_out);
      m_wp = m_count; m_load = 1; m_count++; m_last = g1;
    end
    if (g0) pend0 = 0;
    if (g1) pend1 = 0;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load_en"}, load_en, 0);
    chk({tag, "_wp"}, write_pointer, 0);
    chk({tag, "_rp"}, read_pointer, 0);
    chk({tag, "_payload"}, {opcode, operand_a, operand_b}, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic fill_to(input int n, input int p0, input int p1);
    for (int i = 0; i < 200 && m_count < n; i++) begin drive_reqs(p0, p1); tick(); end
    pend0 = 0; pend1 = 0; drive_reqs(0, 0);
    chk("fill_count", count, n);
  endtask

  int order[$];
  logic [OP_W-1:0] res[$];
  int done_at, nrv;

  initial begin
    model_reset();
    pend0 = 0; pend1 = 0; it0 = '0; it1 = '0;
    #3;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Contention: both held, expect 0,1,0,1
    for (int i = 0; i < 12 && order.size() < 4; i++) begin
      drive_reqs(100, 100); tick();
      if (seen0) order.push_back(0);
      if (seen1) order.push_back(1);
    end
    chk("cont_grants", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++) chk("cont_order", order[k], k % 2);
    pend0 = 0; pend1 = 0; drive_reqs(0, 0);

    // Playback of ADD 5,3 then SUB 9,4
    clear = 1; tick(); clear = 0;
    it0 = {OPC_ADD, 32'd5, 32'd3}; pend0 = 1; drive_reqs(0, 0); tick();
    it0 = {OPC_SUB, 32'd9, 32'd4}; pend0 = 1; drive_reqs(0, 0); tick();
    drive_reqs(0, 0);
    start = 1; tick(); start = 0;
    done_at = -1;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid) res.push_back(alu(tbmem[read_pointer]));
      if (done && done_at < 0) done_at = i;
      tick();
    end
    chk("pb_nres", res.size(), 2);
    chk("pb_res0", res.size() > 0 ? res[0] : '1, 8);
    chk("pb_res1", res.size() > 1 ? res[1] : '1, 5);
    chk("pb_done_cycle", done_at, 2);

    // start + req0 together with an empty store
    clear = 1; tick(); clear = 0;
    drive_reqs(100, 0); start = 1; tick(); start = 0;
    chk("pri_no_gnt", seen0, 0);
    chk("empty_done", done, 1);
    chk("empty_rdv", rd_valid, 0);
    tick();
    pend0 = 0; drive_reqs(0, 0);

    // clear/start during PLAY are ignored
    clear = 1; tick(); clear = 0;
    fill_to(6, 60, 60);
    start = 1; tick(); start = 0;
    nrv = 0;
    if (rd_valid) nrv++;
    tick();
    if (rd_valid) nrv++;
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    for (int i = 0; i < 40 && busy; i++) begin if (rd_valid) nrv++; tick(); end
    chk("ign_rdv_cycles", nrv, 6);
    chk("ign_count", count, 6);

    // Full: 32 writes, then req0 held gets nothing until clear
    clear = 1; tick(); clear = 0;
    fill_to(32, 100, 100);
    drive_reqs(100, 0);
    for (int i = 0; i < 5; i++) begin tick(); chk("full_gnt0", seen0, 0); end
    chk("full_flag", full, 1);
    chk("full_count", count, 32);
    clear = 1; tick(); clear = 0;
    chk("clr_count", count, 0);
    tick();
    chk("clr_wp0", write_pointer, 0);
    chk("clr_load", load_en, 1);
    drive_reqs(0, 0);

    // Reset during PLAY
    clear = 1; tick(); clear = 0;
    fill_to(3, 100, 0);
    start = 1; tick(); start = 0;
    chk("rst_pre_rdv", rd_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("rst_play");
    model_reset();
    @(posedge clk); #1;
    chk("rst_no_done", done, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Random traffic with occasional commands
    for (int i = 0; i < 1500; i++) begin
      drive_reqs(40, 40);
      clear = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 3);
      tick();
    end
    clear = 0; start = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
